mem2axil_bridge: RTL and testbench

- Converts the PicoRV32 native memory interface (mem_valid/mem_ready) into a single-outstanding AXI4-Lite master.
- Sits between the CPU core and the AXI4-Lite slaves, RAM included.
- Issues one read or write per CPU request and returns data and completion to the core.
- Flags slave error responses for the system.

---
 rtl/mem2axil_bridge_if.sv | 91 +++++++++
 rtl/mem2axil_bridge.sv | 168 ++++++++++++++++
 tb/tb_mem2axil_bridge.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem2axil_bridge_if.sv
// ---------------------------------------------------------------------------
// mem2axil_bridge_if
//
// Bundles the CPU-side native memory interface (mem_valid/mem_ready, as used
// by PicoRV32) together with the five AXI4-Lite channels that the bridge
// drives.
//
// Modports:
//   master : the bridge's view. It receives CPU requests, returns mem_ready
//            and mem_rdata, and acts as the AXI4-Lite master.
//   slave  : the environment's view. The CPU drives the requests, and the
//            AXI4-Lite slave answers on the AW/W/B/AR/R channels.
//
// Parameters:
//   ADDR_WIDTH : byte address width (mem_addr, awaddr, araddr)
//   DATA_WIDTH : data width; the strobe width is DATA_WIDTH/8
// ---------------------------------------------------------------------------
interface mem2axil_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // CPU native memory interface
  logic                  mem_valid;
  logic                  mem_instr;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // AXI4-Lite write address channel
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;

  // AXI4-Lite write data channel
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;

  // AXI4-Lite write response channel
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  // AXI4-Lite read address channel
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  // AXI4-Lite read data channel
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/mem2axil_bridge.sv
// ---------------------------------------------------------------------------
// mem2axil_bridge
//
// Turns PicoRV32 native memory requests into single-outstanding AXI4-Lite
// transactions. A request with a non-zero wstrb becomes a write, and a
// request with wstrb == 0 becomes a read. Completion is returned to the core
// as a one-cycle mem_ready pulse. Responses other than OKAY are flagged on
// bus_err, and they are also logged in err_addr and in a saturating
// err_count.
//
// Ports:
//   clk       : system clock, rising edge
//   resetn    : asynchronous active-low reset; clears every output
//   bus       : CPU + AXI4-Lite bundle (mem2axil_bridge_if.master)
//   bus_err   : one-cycle pulse, coincident with mem_ready, on a non-OKAY resp
//   err_addr  : address of the most recent errored transaction
//   err_count : saturating count of errored transactions
//
// Only DATA_WIDTH = 32 is supported.
// ---------------------------------------------------------------------------
module mem2axil_bridge #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  mem2axil_bridge_if.master        bus,
  output logic                     bus_err,
  output logic [ADDR_WIDTH-1:0]    err_addr,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  state_t state;

  // Completion events. The response is taken straight from the channel on
  // the edge that enters DONE, so mem_ready, bus_err and the error log all
  // become visible in the same DONE cycle.
  logic                  wr_fin;
  logic                  rd_fin;
  logic [1:0]            fin_resp;
  logic [ADDR_WIDTH-1:0] fin_addr;
  logic                  aw_fin;
  logic                  w_fin;

  always_comb begin
    wr_fin   = (state == WR_RESP) && bus.m_axi_bvalid && bus.m_axi_bready;
    rd_fin   = (state == RD_RESP) && bus.m_axi_rvalid && bus.m_axi_rready;
    fin_resp = wr_fin ? bus.m_axi_bresp : bus.m_axi_rresp;
    fin_addr = wr_fin ? bus.m_axi_awaddr : bus.m_axi_araddr;
    // A channel counts as finished once its valid has dropped, or when it
    // is handshaking on this edge.
    aw_fin   = !bus.m_axi_awvalid || bus.m_axi_awready;
    w_fin    = !bus.m_axi_wvalid  || bus.m_axi_wready;
  end

  // NOTE: every output is a flop inside this one clocked block, and all of
  // them are assigned with <=. Every flop therefore samples the values from
  // before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      bus.mem_ready     <= 1'b0;
      bus.mem_rdata     <= '0;
      bus.m_axi_awaddr  <= '0;
      bus.m_axi_awprot  <= 3'b000;
      bus.m_axi_awvalid <= 1'b0;
      bus.m_axi_wdata   <= '0;
      bus.m_axi_wstrb   <= '0;
      bus.m_axi_wvalid  <= 1'b0;
      bus.m_axi_bready  <= 1'b0;
      bus.m_axi_araddr  <= '0;
      bus.m_axi_arprot  <= 3'b000;
      bus.m_axi_arvalid <= 1'b0;
      bus.m_axi_rready  <= 1'b0;
      bus_err           <= 1'b0;
      err_addr          <= '0;
      err_count         <= '0;
    end else begin
      // Single-cycle pulses default low.
      bus.mem_ready <= 1'b0;
      bus_err       <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.mem_valid) begin
            if (|bus.mem_wstrb) begin
              bus.m_axi_awaddr  <= bus.mem_addr;
              bus.m_axi_awprot  <= {bus.mem_instr, 2'b00};
              bus.m_axi_wdata   <= bus.mem_wdata;
              bus.m_axi_wstrb   <= bus.mem_wstrb;
              bus.m_axi_awvalid <= 1'b1;
              bus.m_axi_wvalid  <= 1'b1;
              state             <= WR_REQ;
            end else begin
              bus.m_axi_araddr  <= bus.mem_addr;
              bus.m_axi_arprot  <= {bus.mem_instr, 2'b00};
              bus.m_axi_arvalid <= 1'b1;
              state             <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          // AW and W retire independently, and their payloads stay put.
          if (bus.m_axi_awready) bus.m_axi_awvalid <= 1'b0;
          if (bus.m_axi_wready)  bus.m_axi_wvalid  <= 1'b0;
          // bready is raised only after both handshakes have completed, so
          // an early bvalid from the slave is held off.
          if (aw_fin && w_fin) begin
            bus.m_axi_bready <= 1'b1;
            state            <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bus.m_axi_bvalid) begin
            bus.m_axi_bready <= 1'b0;
            state            <= DONE;
          end
        end

        RD_REQ: begin
          if (bus.m_axi_arready) begin
            bus.m_axi_arvalid <= 1'b0;
            bus.m_axi_rready  <= 1'b1;
            state             <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (bus.m_axi_rvalid) begin
            bus.m_axi_rready <= 1'b0;
            state            <= DONE;
          end
        end

        DONE: begin
          // mem_rdata is only meaningful while mem_ready is high.
          bus.mem_rdata <= '0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase

      if (wr_fin || rd_fin) begin
        bus.mem_ready <= 1'b1;
        bus.mem_rdata <= rd_fin ? bus.m_axi_rdata : '0;
        if (fin_resp != 2'b00) begin
          bus_err  <= 1'b1;
          err_addr <= fin_addr;
          if (err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem2axil_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem2axil_bridge
//
// Directed bench for mem2axil_bridge. It contains a small AXI4-Lite RAM
// slave with programmable ready/response delays. The slave answers
// SLVERR (2'b10) to any read of address 0x0000_4000.
// ---------------------------------------------------------------------------
module tb_mem2axil_bridge;

  logic        clk;
  logic        resetn;
  logic        bus_err;
  logic [31:0] err_addr;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_pass   = 0;

  mem2axil_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem2axil_bridge #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .ERR_CNT_WIDTH(8)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .bus_err  (bus_err),
    .err_addr (err_addr),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AXI4-Lite RAM slave model ----------------
  int aw_delay = 0;
  int w_delay  = 0;
  int b_delay  = 0;
  int ar_delay = 0;
  int r_delay  = 0;

  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic        have_aw, have_w, have_ar;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic [31:0] ram [16];

  assign bus.m_axi_awready = bus.m_axi_awvalid && (aw_wait >= aw_delay);
  assign bus.m_axi_wready  = bus.m_axi_wvalid  && (w_wait  >= w_delay);
  assign bus.m_axi_arready = bus.m_axi_arvalid && (ar_wait >= ar_delay);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      have_aw <= 1'b0; have_w <= 1'b0; have_ar <= 1'b0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_araddr <= '0;
      bus.m_axi_bvalid <= 1'b0;
      bus.m_axi_bresp  <= 2'b00;
      bus.m_axi_rvalid <= 1'b0;
      bus.m_axi_rresp  <= 2'b00;
      bus.m_axi_rdata  <= '0;
    end else begin
      if (bus.m_axi_awvalid && !bus.m_axi_awready) aw_wait <= aw_wait + 1;
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        aw_wait <= 0; have_aw <= 1'b1; s_awaddr <= bus.m_axi_awaddr;
      end
      if (bus.m_axi_wvalid && !bus.m_axi_wready) w_wait <= w_wait + 1;
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_wait <= 0; have_w <= 1'b1;
        s_wdata <= bus.m_axi_wdata; s_wstrb <= bus.m_axi_wstrb;
      end
      if (have_aw && have_w && !bus.m_axi_bvalid) begin
        if (b_wait >= b_delay) begin
          b_wait <= 0;
          bus.m_axi_bvalid <= 1'b1;
          bus.m_axi_bresp  <= 2'b00;
          for (int i = 0; i < 4; i++)
            if (s_wstrb[i]) ram[s_awaddr[5:2]][8*i +: 8] <= s_wdata[8*i +: 8];
        end else begin
          b_wait <= b_wait + 1;
        end
      end
      if (bus.m_axi_bvalid && bus.m_axi_bready) begin
        bus.m_axi_bvalid <= 1'b0; have_aw <= 1'b0; have_w <= 1'b0;
      end

      if (bus.m_axi_arvalid && !bus.m_axi_arready) ar_wait <= ar_wait + 1;
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        ar_wait <= 0; have_ar <= 1'b1; s_araddr <= bus.m_axi_araddr;
      end
      if (have_ar && !bus.m_axi_rvalid) begin
        if (r_wait >= r_delay) begin
          r_wait <= 0;
          bus.m_axi_rvalid <= 1'b1;
          bus.m_axi_rdata  <= ram[s_araddr[5:2]];
          bus.m_axi_rresp  <= (s_araddr == 32'h0000_4000) ? 2'b10 : 2'b00;
        end else begin
          r_wait <= r_wait + 1;
        end
      end
      if (bus.m_axi_rvalid && bus.m_axi_rready) begin
        bus.m_axi_rvalid <= 1'b0; have_ar <= 1'b0;
      end
    end
  end

  // ---------------- checking and CPU-side helpers ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at a negedge. The request is presented for one clock and
  // sampled by the DUT in IDLE. The task returns at the next negedge.
  task automatic start_req(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic instr);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
    bus.mem_instr = instr;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    bus.mem_instr = 1'b0;
  endtask

  // Waits (bounded) for mem_ready, samples rdata/bus_err in that cycle,
  // then checks that the pulse is exactly one cycle wide.
  task automatic finish_req(input string tag, output logic [31:0] rd,
                            output logic err);
    logic ok;
    ok = 1'b0;
    rd = '0;
    err = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.mem_ready) begin
        ok = 1'b1; rd = bus.mem_rdata; err = bus_err;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done"}, {31'd0, ok}, 32'd1);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, bus.mem_ready}, 32'd0);
  endtask

  task automatic access(input string tag, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic err);
    start_req(a, d, s, 1'b0);
    finish_req(tag, rd, err);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  logic        err;
  int          aw_hi, w_hi, unstable, early_b, ready_cnt;

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_awvalid", {31'd0, bus.m_axi_awvalid}, 32'd0);
    check("rst_wvalid",  {31'd0, bus.m_axi_wvalid},  32'd0);
    check("rst_arvalid", {31'd0, bus.m_axi_arvalid}, 32'd0);
    check("rst_bready",  {31'd0, bus.m_axi_bready},  32'd0);
    check("rst_rready",  {31'd0, bus.m_axi_rready},  32'd0);
    check("rst_ready",   {31'd0, bus.mem_ready},     32'd0);
    check("rst_buserr",  {31'd0, bus_err},           32'd0);
    check("rst_errcnt",  {24'd0, err_count},         32'd0);
    check("rst_erraddr", err_addr,                   32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Full-word write to 0x10. AW and W must come up together.
    start_req(32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0);
    check("w1_awvalid", {31'd0, bus.m_axi_awvalid}, 32'd1);
    check("w1_wvalid",  {31'd0, bus.m_axi_wvalid},  32'd1);
    check("w1_awaddr",  bus.m_axi_awaddr,           32'h0000_0010);
    check("w1_awprot",  {29'd0, bus.m_axi_awprot},  32'd0);
    check("w1_wdata",   bus.m_axi_wdata,            32'h1234_5678);
    check("w1_wstrb",   {28'd0, bus.m_axi_wstrb},   32'hF);
    finish_req("w1", rd, err);
    check("w1_err",   {31'd0, err}, 32'd0);
    check("w1_rdata", rd,           32'd0);
    access("r1", 32'h0000_0010, 32'd0, 4'h0, rd, err);
    check("r1_rdata", rd,           32'h1234_5678);
    check("r1_err",   {31'd0, err}, 32'd0);

    // Byte write to 0x13 (top byte lane), then read back the word.
    access("w2", 32'h0000_0013, 32'hAB00_0000, 4'h8, rd, err);
    access("r2", 32'h0000_0010, 32'd0, 4'h0, rd, err);
    check("r2_rdata", rd, 32'hAB34_5678);

    // Instruction fetch from 0x0
    access("w3", 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, rd, err);
    start_req(32'h0000_0000, 32'd0, 4'h0, 1'b1);
    check("if_arvalid", {31'd0, bus.m_axi_arvalid}, 32'd1);
    check("if_arprot",  {29'd0, bus.m_axi_arprot},  32'h4);
    check("if_araddr",  bus.m_axi_araddr,           32'h0);
    finish_req("if", rd, err);
    check("if_rdata", rd,           32'hDEAD_BEEF);
    check("if_err",   {31'd0, err}, 32'd0);

    // Stalling slave: awready after 5 cycles, wready after 2, bvalid 3 late.
    // Each valid then stays high for delay+1 sampled cycles.
    aw_delay = 5; w_delay = 2; b_delay = 3;
    start_req(32'h0000_0020, 32'hCAFE_F00D, 4'hF, 1'b0);
    aw_hi = 0; w_hi = 0; unstable = 0; early_b = 0; ready_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.m_axi_awvalid) begin
        aw_hi++;
        if (bus.m_axi_awaddr !== 32'h0000_0020) unstable++;
      end
      if (bus.m_axi_wvalid) begin
        w_hi++;
        if (bus.m_axi_wdata !== 32'hCAFE_F00D || bus.m_axi_wstrb !== 4'hF)
          unstable++;
      end
      if (bus.m_axi_bready && (bus.m_axi_awvalid || bus.m_axi_wvalid))
        early_b++;
      if (bus.mem_ready) ready_cnt++;
      @(negedge clk);
    end
    check("st_aw_cycles", aw_hi,     32'd6);
    check("st_w_cycles",  w_hi,      32'd3);
    check("st_unstable",  unstable,  32'd0);
    check("st_early_b",   early_b,   32'd0);
    check("st_ready_cnt", ready_cnt, 32'd1);
    aw_delay = 0; w_delay = 0; b_delay = 0;
    access("st_r", 32'h0000_0020, 32'd0, 4'h0, rd, err);
    check("st_rdata", rd, 32'hCAFE_F00D);

    // Slave error on reads of 0x4000, then saturation of the error counter.
    access("e1", 32'h0000_4000, 32'd0, 4'h0, rd, err);
    check("e1_buserr",  {31'd0, err},       32'd1);
    check("e1_erraddr", err_addr,           32'h0000_4000);
    check("e1_errcnt",  {24'd0, err_count}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      access("esat", 32'h0000_4000, 32'd0, 4'h0, rd, err);
      if (i == 253) check("e_cnt255", {24'd0, err_count}, 32'hFF);
    end
    check("e_sat_cnt", {24'd0, err_count}, 32'hFF);
    check("e_sat_err", {31'd0, err},       32'd1);

    // Asynchronous reset in the middle of WR_REQ, away from any clock edge.
    aw_delay = 5;
    start_req(32'h0000_0024, 32'h5555_5555, 4'hF, 1'b0);
    @(negedge clk);
    #3 resetn = 1'b0;
    #1;
    check("ar_awvalid", {31'd0, bus.m_axi_awvalid}, 32'd0);
    check("ar_wvalid",  {31'd0, bus.m_axi_wvalid},  32'd0);
    check("ar_bready",  {31'd0, bus.m_axi_bready},  32'd0);
    check("ar_ready",   {31'd0, bus.mem_ready},     32'd0);
    check("ar_errcnt",  {24'd0, err_count},         32'd0);
    aw_delay = 0;
    @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    access("ar_r", 32'h0000_0010, 32'd0, 4'h0, rd, err);
    check("ar_rdata", rd,           32'hAB34_5678);
    check("ar_err",   {31'd0, err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
